// File: rtl/conv_stream_host.sv
// Stream-side host for conv_8_4: drives x/f master streams, sinks y into a result buffer.
// Optional THROTTLE_EN: LFSR-based gating of new beats and y_ready (adds the SEED parameter).
module conv_stream_host #(
  parameter int XLEN = 8,
  parameter int FLEN = 4,
  parameter int DW   = 8,
  parameter int YW   = 18
`ifdef THROTTLE_EN
  ,
  parameter logic [15:0] SEED = 16'hACE1
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_we,
  input  logic                                 cfg_sel,
  input  logic [$clog2(XLEN)-1:0]              cfg_addr,
  input  logic [DW-1:0]                        cfg_wdata,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [DW-1:0]                        x_data,
  output logic                                 x_valid,
  input  logic                                 x_ready,
  output logic [DW-1:0]                        f_data,
  output logic                                 f_valid,
  input  logic                                 f_ready,
  input  logic [YW-1:0]                        y_data,
  input  logic                                 y_valid,
  output logic                                 y_ready,
  input  logic [$clog2(XLEN-FLEN+1)-1:0]       res_addr,
  output logic [YW-1:0]                        res_data
);
  localparam int NY  = XLEN - FLEN + 1;
  localparam int AW  = $clog2(XLEN);
  localparam int FAW = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam int RW  = $clog2(NY);
  localparam int XIW = $clog2(XLEN + 1);
  localparam int FIW = $clog2(FLEN + 1);
  localparam int YIW = $clog2(NY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [DW-1:0]  xbuf [XLEN];
  logic [DW-1:0]  fbuf [FLEN];
  logic [YW-1:0]  res  [NY];

  logic [XIW-1:0] x_idx_reg, x_idx_next;
  logic [FIW-1:0] f_idx_reg, f_idx_next;
  logic [YIW-1:0] y_cnt_reg, y_cnt_next;
  logic           x_valid_reg, x_valid_next;
  logic           f_valid_reg, f_valid_next;
  logic           gate_x, gate_f, gate_y;
  logic           start_ok, x_fire, f_fire, y_fire;
  logic [AW-1:0]  x_sel;
  logic [FAW-1:0] f_sel;

`ifdef THROTTLE_EN
  logic [15:0] lfsr_reg;

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign gate_x = lfsr_reg[0];
  assign gate_f = lfsr_reg[1];
  assign gate_y = lfsr_reg[2];
`else
  assign gate_x = 1'b1;
  assign gate_f = 1'b1;
  assign gate_y = 1'b1;
`endif

  assign start_ok = start && (state_reg != RUN);
  assign x_fire   = x_valid_reg && x_ready;
  assign f_fire   = f_valid_reg && f_ready;
  assign y_ready  = (state_reg == RUN) && (y_cnt_reg < YIW'(NY)) && gate_y;
  assign y_fire   = y_valid && y_ready;

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign x_valid = x_valid_reg;
  assign f_valid = f_valid_reg;

  // Terminal index values are never used to address the buffers; clamp to keep reads in range
  assign x_sel  = (x_idx_reg < XIW'(XLEN)) ? x_idx_reg[AW-1:0] : '0;
  assign f_sel  = (f_idx_reg < FIW'(FLEN)) ? f_idx_reg[FAW-1:0] : '0;
  assign x_data = xbuf[x_sel];
  assign f_data = fbuf[f_sel];

  always_comb begin
    x_idx_next = x_idx_reg + XIW'(x_fire);
    f_idx_next = f_idx_reg + FIW'(f_fire);
    y_cnt_next = y_cnt_reg + YIW'(y_fire);
    if (start_ok) begin
      x_idx_next = '0;
      f_idx_next = '0;
      y_cnt_next = '0;
    end
  end

  // Completion uses post-edge counts so done rises right after the last beat
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (x_idx_next == XIW'(XLEN) && f_idx_next == FIW'(FLEN) && y_cnt_next == YIW'(NY))
                 state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // A pending beat is never withdrawn; gates only hold off the next one
  always_comb begin
    if (x_valid_reg && !x_ready) x_valid_next = 1'b1;
    else x_valid_next = (state_next == RUN) && (x_idx_next < XIW'(XLEN)) && gate_x;
    if (f_valid_reg && !f_ready) f_valid_next = 1'b1;
    else f_valid_next = (state_next == RUN) && (f_idx_next < FIW'(FLEN)) && gate_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      x_idx_reg   <= '0;
      f_idx_reg   <= '0;
      y_cnt_reg   <= '0;
      x_valid_reg <= 1'b0;
      f_valid_reg <= 1'b0;
      res_data    <= '0;
    end else begin
      state_reg   <= state_next;
      x_idx_reg   <= x_idx_next;
      f_idx_reg   <= f_idx_next;
      y_cnt_reg   <= y_cnt_next;
      x_valid_reg <= x_valid_next;
      f_valid_reg <= f_valid_next;
      res_data    <= (32'(res_addr) < NY) ? res[res_addr] : '0;
    end
  end

  // Buffers hold their contents across reset
  always_ff @(posedge clk) begin
    if (cfg_we && state_reg == IDLE) begin
      if (!cfg_sel) xbuf[cfg_addr] <= cfg_wdata;
      else if (32'(cfg_addr) < FLEN) fbuf[cfg_addr[FAW-1:0]] <= cfg_wdata;
    end
    if (y_fire) res[y_cnt_reg[RW-1:0]] <= y_data;
  end

endmodule

// File: tb/tb_conv_stream_host.sv
// Scoreboard bench for conv_stream_host with a behavioural conv_8_4 correlator model on the y side.
module tb_conv_stream_host;
  localparam int XLEN = 8;
  localparam int FLEN = 4;
  localparam int DW   = 8;
  localparam int YW   = 18;
  localparam int NY   = XLEN - FLEN + 1;

  logic          clk = 1'b0;
  logic          reset, cfg_we, cfg_sel, start;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          busy, done;
  logic [DW-1:0] x_data, f_data;
  logic          x_valid, x_ready, f_valid, f_ready;
  logic [YW-1:0] y_data;
  logic          y_valid, y_ready;
  logic [2:0]    res_addr;
  logic [YW-1:0] res_data;

  always #5 clk = ~clk;

  conv_stream_host #(.XLEN(XLEN), .FLEN(FLEN), .DW(DW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .res_addr(res_addr), .res_data(res_data)
  );

  int     chk_cnt = 0;
  int     pass_cnt = 0;
  int     exp_x[$], exp_f[$], exp_r[$];
  int     xv[XLEN], fv[FLEN], yexp[NY];
  int     rx_arr[XLEN], rf_arr[FLEN];
  int     rx_cnt = 0, rf_cnt = 0, ym_cnt = 0;
  bit     done_chk = 0, stall_x = 0, stall_f = 0, prev_rst = 0;
  bit     rd_req = 0, rd_req_d = 0;
  logic [DW-1:0] px, pf;
  longint cyc = 0, t_start = 0, x_first = 0, x_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint expv);
    chk_cnt++;
    if (got == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: pops expected beats on handshakes, checks hold rules, read data and done timing
  always @(negedge clk) begin
    if (stall_x && !prev_rst) begin
      check("x_hold_valid", x_valid, 1);
      check("x_hold_data", $signed(x_data), $signed(px));
    end
    if (stall_f && !prev_rst) begin
      check("f_hold_valid", f_valid, 1);
      check("f_hold_data", $signed(f_data), $signed(pf));
    end
    stall_x  = x_valid && !x_ready;
    stall_f  = f_valid && !f_ready;
    px       = x_data;
    pf       = f_data;
    prev_rst = reset;
    if (done_chk) begin
      check("done_after_last_y", done, 1);
      done_chk = 0;
    end
    if (start) begin
      rx_cnt = 0;
      rf_cnt = 0;
      ym_cnt = 0;
    end
    if (x_valid && x_ready) begin
      if (exp_x.size() == 0) timeout("x_extra_beat");
      else check("x_beat", $signed(x_data), exp_x.pop_front());
      if (rx_cnt == 0) x_first = cyc;
      x_last = cyc;
      if (rx_cnt < XLEN) rx_arr[rx_cnt] = int'($signed(x_data));
      rx_cnt++;
    end
    if (f_valid && f_ready) begin
      if (exp_f.size() == 0) timeout("f_extra_beat");
      else check("f_beat", $signed(f_data), exp_f.pop_front());
      if (rf_cnt < FLEN) rf_arr[rf_cnt] = int'($signed(f_data));
      rf_cnt++;
    end
    if (y_valid && y_ready) begin
      ym_cnt++;
      if (ym_cnt == NY) done_chk = 1;
    end
    if (rd_req_d) begin
      if (exp_r.size() == 0) timeout("res_extra_read");
      else check("res_read", $signed(res_data), exp_r.pop_front());
    end
    rd_req_d = rd_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input bit sel, input int a, input int v);
    cfg_we = 1; cfg_sel = sel; cfg_addr = a[2:0]; cfg_wdata = v[DW-1:0];
    tick();
    cfg_we = 0;
  endtask

  task automatic load_buffers();
    for (int i = 0; i < XLEN; i++) cfg_write(0, i, xv[i]);
    for (int i = 0; i < FLEN; i++) cfg_write(1, i, fv[i]);
  endtask

  task automatic push_expect();
    for (int i = 0; i < XLEN; i++) exp_x.push_back(xv[i]);
    for (int i = 0; i < FLEN; i++) exp_f.push_back(fv[i]);
  endtask

  task automatic start_run();
    start = 1;
    tick();
    start = 0;
    t_start = cyc;
  endtask

  task automatic wait_streams(input bit do_stall);
    int  guard;
    bit  stalled;
    guard = 0;
    stalled = 0;
    while ((rx_cnt < XLEN || rf_cnt < FLEN) && guard < 400) begin
      if (do_stall && !stalled && rx_cnt == 4 && x_valid) begin
        stalled = 1;
        x_ready = 0;
        for (int i = 0; i < 5; i++) begin
          check("stall_x_valid", x_valid, 1);
          check("stall_x_data", $signed(x_data), xv[4]);
          tick();
        end
        x_ready = 1;
      end
      tick();
      guard++;
    end
    if (guard >= 400) timeout("stream_beats");
  endtask

  // conv_8_4 model: y[n] = sum_k f[k]*x[n+k] over the beats actually received
  task automatic drive_y();
    longint acc;
    bit     ok;
    int     g;
    for (int n = 0; n < NY; n++) begin
      acc = 0;
      for (int k = 0; k < FLEN; k++) acc += longint'(rf_arr[k]) * longint'(rx_arr[n+k]);
      y_valid = 1;
      y_data  = acc[YW-1:0];
      ok = 0;
      g  = 0;
      while (!ok && g < 400) begin
        @(negedge clk);
        ok = y_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!ok) timeout("y_beat_accept");
    end
    y_valid = 0;
  endtask

  task automatic finish_run();
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
  endtask

  task automatic read_res();
    for (int a = 0; a < NY; a++) begin
      exp_r.push_back(yexp[a]);
      res_addr = a[2:0];
      rd_req = 1;
      tick();
    end
    rd_req = 0;
    tick();
    tick();
  endtask

  task automatic idle_y_probe(input string name);
    y_valid = 1;
    y_data  = 18'd7;
    for (int i = 0; i < 3; i++) begin
      check(name, y_ready, 0);
      tick();
    end
    y_valid = 0;
  endtask

  initial begin
    reset = 1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_wdata = 0; start = 0;
    x_ready = 1; f_ready = 1; y_valid = 0; y_data = 0; res_addr = 0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_f_valid", f_valid, 0);
    check("rst_y_ready", y_ready, 0);
    check("rst_res_data", res_data, 0);
    reset = 0;
    tick();

    // Run 1: signed data, ready held high
    xv   = '{10, -20, 30, -40, 50, 60, 70, 80};
    fv   = '{10, 20, -30, 40};
    yexp = '{-2800, 3600, 400, 1600, 2800};
    load_buffers();
    push_expect();
    start_run();
    check("valid_after_start", x_valid & f_valid, 1);
    wait_streams(0);
    drive_y();
    finish_run();
`ifdef THROTTLE_EN
    check("throttled_slower", (cyc - t_start) > 13, 1);
`else
    check("run_cycles", cyc - t_start, 13);
    check("x_back_to_back", x_last - x_first, XLEN - 1);
`endif
    read_res();

    // Extra y beat after NY while DONE is refused, results untouched
    idle_y_probe("y_ready_after_ny");
    read_res();

    // Restart from DONE with the same buffers: streams replay from index 0
    push_expect();
    start_run();
    check("busy_restart", busy, 1);
    wait_streams(0);
    drive_y();
    finish_run();
    read_res();

    // Back to IDLE, rewrite buffers; x[0] written in the start cycle; x stalled mid-stream
    reset = 1;
    tick();
    reset = 0;
    xv   = '{1, 2, 3, 4, 5, 6, 7, 8};
    fv   = '{1, 1, 1, 1};
    yexp = '{10, 14, 18, 22, 26};
    cfg_write(0, 0, 99);
    for (int i = 1; i < XLEN; i++) cfg_write(0, i, xv[i]);
    for (int i = 0; i < FLEN; i++) cfg_write(1, i, fv[i]);
    push_expect();
    cfg_we = 1; cfg_sel = 0; cfg_addr = 3'd0; cfg_wdata = 8'd1;
    start_run();
    cfg_we = 0;
    wait_streams(1);
    drive_y();
    finish_run();
    read_res();

    // Reset mid-run after 3 x beats, then replay from x[0]
    push_expect();
    start_run();
    begin
      int g;
      g = 0;
      while (rx_cnt < 3 && g < 100) begin
        tick();
        g++;
      end
      if (g >= 100) timeout("three_x_beats");
    end
    x_ready = 0;
    f_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_x_valid", x_valid, 0);
    check("midrun_rst_f_valid", f_valid, 0);
    x_ready = 1;
    f_ready = 1;
    exp_x.delete();
    exp_f.delete();
    push_expect();
    start_run();
    wait_streams(0);
    drive_y();
    finish_run();
    read_res();

    // y_valid while IDLE is never accepted
    reset = 1;
    tick();
    reset = 0;
    tick();
    idle_y_probe("y_ready_idle");
    read_res();

    check("x_queue_drained", exp_x.size(), 0);
    check("f_queue_drained", exp_f.size(), 0);
    check("res_queue_drained", exp_r.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
